// File: rtl/touch_brush_painter.sv
// rtl/touch_brush_painter.sv - clears VRAM, then paints clipped square brushes around touch points
// Define PAINTER_DEDUP_EN to skip repainting a channel whose point has not moved since its last paint.
module touch_brush_painter #(
   parameter int DISPLAY_WIDTH  = 240,
   parameter int DISPLAY_HEIGHT = 320,
   parameter int N_CH           = 2,
   parameter int BRUSH_R        = 1,
   parameter int COLOR_W        = 16,
   localparam int X_W    = $clog2(DISPLAY_WIDTH),
   localparam int Y_W    = $clog2(DISPLAY_HEIGHT),
   localparam int ADDR_W = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear_req,
   input  logic [COLOR_W-1:0]      bg_color,
   input  logic [N_CH-1:0]         touch_valid,
   input  logic [N_CH*X_W-1:0]     touch_x,
   input  logic [N_CH*Y_W-1:0]     touch_y,
   input  logic [N_CH*COLOR_W-1:0] ch_color,
   output logic                    vram_wr_ena,
   output logic [ADDR_W-1:0]       vram_wr_addr,
   output logic [COLOR_W-1:0]      vram_wr_data,
   output logic                    clearing,
   output logic                    busy
);

   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int OFF_W = 4;
   localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DISPLAY_WIDTH * DISPLAY_HEIGHT - 1);
   localparam logic [OFF_W-1:0]    SPAN      = OFF_W'(2 * BRUSH_R);
   localparam logic signed [X_W:0] X_LIM     = (X_W+1)'(DISPLAY_WIDTH);
   localparam logic signed [Y_W:0] Y_LIM     = (Y_W+1)'(DISPLAY_HEIGHT);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PAINT} state_t;

   state_t state, next_state;

   logic [ADDR_W-1:0]  clr_cnt;
   logic [CH_W-1:0]    rr_ptr, cur_ch;
   logic [X_W-1:0]     cx, st_x;
   logic [Y_W-1:0]     cy, st_y;
   logic [COLOR_W-1:0] cur_color, st_color;
   logic [OFF_W-1:0]   ox, oy;
   logic               st_valid;

   logic               sel_found, sel_in_range, sel_dup, load_point, skip_ch, paint_last;
   logic [CH_W-1:0]    sel_ch, sel_next, cur_next;
   logic [X_W-1:0]     sel_x;
   logic [Y_W-1:0]     sel_y;
   logic signed [X_W:0] px;
   logic signed [Y_W:0] py;
   logic               pix_ok;
   logic [ADDR_W-1:0]  pix_addr;
   int                 idx;

   // Round-robin scan starting at rr_ptr, wrapping modulo N_CH.
   always_comb begin
      sel_found = 1'b0;
      sel_ch    = '0;
      idx       = 0;
      for (int i = 0; i < N_CH; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!sel_found && touch_valid[idx]) begin
            sel_found = 1'b1;
            sel_ch    = CH_W'(idx);
         end
      end
   end

   assign sel_x        = touch_x[int'(sel_ch)*X_W +: X_W];
   assign sel_y        = touch_y[int'(sel_ch)*Y_W +: Y_W];
   assign sel_in_range = (int'(sel_x) < DISPLAY_WIDTH) && (int'(sel_y) < DISPLAY_HEIGHT);
   assign sel_next     = (int'(sel_ch) == N_CH - 1) ? '0 : sel_ch + 1'b1;
   assign cur_next     = (int'(cur_ch) == N_CH - 1) ? '0 : cur_ch + 1'b1;

   // Clip in signed space before any address is formed, so off-screen offsets never alias.
   assign px       = {1'b0, cx} + (X_W+1)'(ox) - (X_W+1)'(BRUSH_R);
   assign py       = {1'b0, cy} + (Y_W+1)'(oy) - (Y_W+1)'(BRUSH_R);
   assign pix_ok   = !px[X_W] && (px < X_LIM) && !py[Y_W] && (py < Y_LIM);
   assign pix_addr = ADDR_W'(st_y) * ADDR_W'(DISPLAY_WIDTH) + ADDR_W'(st_x);
   assign paint_last = (ox == SPAN) && (oy == SPAN);

`ifdef PAINTER_DEDUP_EN
   logic [X_W-1:0]  last_x [N_CH];
   logic [Y_W-1:0]  last_y [N_CH];
   logic [N_CH-1:0] last_ok;

   assign sel_dup = last_ok[sel_ch] && (last_x[sel_ch] == sel_x) && (last_y[sel_ch] == sel_y);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_ok <= '0;
         for (int i = 0; i < N_CH; i++) begin
            last_x[i] <= '0;
            last_y[i] <= '0;
         end
      end else if (state == S_CLEAR) begin
         last_ok <= '0;
      end else if (load_point) begin
         last_ok[sel_ch] <= 1'b1;
         last_x[sel_ch]  <= sel_x;
         last_y[sel_ch]  <= sel_y;
      end
   end
`else
   assign sel_dup = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_CLEAR;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      load_point = 1'b0;
      skip_ch    = 1'b0;
      case (state)
         S_CLEAR: if (clr_cnt == '0) next_state = S_IDLE;
         S_IDLE: begin
            if (clear_req) begin
               next_state = S_CLEAR;
            end else if (sel_found) begin
               if (sel_in_range && !sel_dup) begin
                  load_point = 1'b1;
                  next_state = S_PAINT;
               end else begin
                  skip_ch = 1'b1;
               end
            end
         end
         S_PAINT: begin
            if (clear_req)       next_state = S_CLEAR;
            else if (paint_last) next_state = S_IDLE;
         end
         default: next_state = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clr_cnt      <= LAST_ADDR;
         rr_ptr       <= '0;
         cur_ch       <= '0;
         cx           <= '0;
         cy           <= '0;
         cur_color    <= '0;
         ox           <= '0;
         oy           <= '0;
         st_valid     <= 1'b0;
         st_x         <= '0;
         st_y         <= '0;
         st_color     <= '0;
         vram_wr_ena  <= 1'b0;
         vram_wr_addr <= '0;
         vram_wr_data <= '0;
         clearing     <= 1'b1;
         busy         <= 1'b1;
      end else begin
         clr_cnt <= (state == S_CLEAR) ? clr_cnt - 1'b1 : LAST_ADDR;

         if (load_point) begin
            cx        <= sel_x;
            cy        <= sel_y;
            cur_ch    <= sel_ch;
            cur_color <= ch_color[int'(sel_ch)*COLOR_W +: COLOR_W];
            ox        <= '0;
            oy        <= '0;
         end else if (state == S_PAINT) begin
            if (ox == SPAN) begin
               ox <= '0;
               oy <= oy + 1'b1;
            end else begin
               ox <= ox + 1'b1;
            end
         end

         if (skip_ch) rr_ptr <= sel_next;
         else if (state == S_PAINT && !clear_req && paint_last) rr_ptr <= cur_next;

         // One-deep pixel stage; an abort drops the next pixel but lets the staged one land.
         st_valid <= (state == S_PAINT) && !clear_req && pix_ok;
         st_x     <= px[X_W-1:0];
         st_y     <= py[Y_W-1:0];
         st_color <= cur_color;

         if (state == S_CLEAR) begin
            vram_wr_ena  <= 1'b1;
            vram_wr_addr <= clr_cnt;
            vram_wr_data <= bg_color;
         end else begin
            vram_wr_ena <= st_valid;
            if (st_valid) begin
               vram_wr_addr <= pix_addr;
               vram_wr_data <= st_color;
            end
         end

         clearing <= (next_state == S_CLEAR);
         busy     <= (next_state != S_IDLE);
      end
   end

endmodule

// File: tb/tb_touch_brush_painter.sv
// tb/tb_touch_brush_painter.sv - directed self-checking bench for touch_brush_painter
module tb_touch_brush_painter;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_req;
   logic [15:0] bg_color;
   logic [1:0]  touch_valid;
   logic [15:0] touch_x;
   logic [17:0] touch_y;
   logic [31:0] ch_color;
   logic        vram_wr_ena;
   logic [16:0] vram_wr_addr;
   logic [15:0] vram_wr_data;
   logic        clearing;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;
   int busy_cnt;
   int wr_addr[$];
   int wr_data[$];

   touch_brush_painter dut (
      .clk          (clk),
      .rst          (rst),
      .clear_req    (clear_req),
      .bg_color     (bg_color),
      .touch_valid  (touch_valid),
      .touch_x      (touch_x),
      .touch_y      (touch_y),
      .ch_color     (ch_color),
      .vram_wr_ena  (vram_wr_ena),
      .vram_wr_addr (vram_wr_addr),
      .vram_wr_data (vram_wr_data),
      .clearing     (clearing),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic record();
      step();
      if (busy) busy_cnt++;
      if (vram_wr_ena) begin
         wr_addr.push_back(int'(vram_wr_addr));
         wr_data.push_back(int'(vram_wr_data));
      end
   endtask

   task automatic set_point(input int ch, input int x, input int y, input logic [15:0] col);
      touch_x[ch*8 +: 8]   = 8'(x);
      touch_y[ch*9 +: 9]   = 9'(y);
      ch_color[ch*16 +: 16] = col;
   endtask

   task automatic reset_capture();
      wr_addr.delete();
      wr_data.delete();
      busy_cnt = 0;
   endtask

   // Present a point for exactly one IDLE sample, then capture the resulting burst.
   task automatic paint_once(input int ch, input int x, input int y, input logic [15:0] col);
      reset_capture();
      set_point(ch, x, y, col);
      touch_valid[ch] = 1'b1;
      step();
      if (busy) busy_cnt++;
      touch_valid = '0;
      for (int i = 0; i < 14; i++) record();
   endtask

   task automatic hold_capture(input logic [1:0] mask, input int hold, input int drain);
      reset_capture();
      touch_valid = mask;
      for (int i = 0; i < hold; i++) record();
      touch_valid = '0;
      for (int i = 0; i < drain; i++) record();
   endtask

   initial begin
      int exp_addr;
      int cnt;
      int bad;
      int gaps;
      int exp_n;
      int exp2[9];
      int exp3a[4];
      int exp3b[4];

      rst = 1'b0;
      clear_req = 1'b0;
      bg_color = 16'h000F;
      touch_valid = '0;
      touch_x = '0;
      touch_y = '0;
      ch_color = '0;
      repeat (3) step();
      check("rst_ena", vram_wr_ena, 0);
      check("rst_addr", vram_wr_addr, 0);
      check("rst_data", vram_wr_data, 0);
      check("rst_clearing", clearing, 1);
      check("rst_busy", busy, 1);

      // Full clear after reset release.
      rst = 1'b1;
      exp_addr = 76799;
      cnt = 0;
      bad = 0;
      gaps = 0;
      for (int i = 0; i < 80000 && cnt < 76800; i++) begin
         step();
         if (vram_wr_ena) begin
            if (int'(vram_wr_addr) != exp_addr || vram_wr_data != 16'h000F) bad++;
            exp_addr--;
            cnt++;
         end else begin
            gaps++;
         end
      end
      check("clear_count", cnt, 76800);
      check("clear_bad_writes", bad, 0);
      check("clear_gaps", gaps, 0);
      check("clear_done_clearing", clearing, 0);
      check("clear_done_busy", busy, 0);
      step();
      check("idle_ena", vram_wr_ena, 0);

      // Interior point: latency and 3x3 address order.
      exp2 = '{11859, 11860, 11861, 12099, 12100, 12101, 12339, 12340, 12341};
      reset_capture();
      set_point(0, 100, 50, 16'hF81F);
      touch_valid[0] = 1'b1;
      step();
      touch_valid = '0;
      step();
      check("lat_edge1_ena", vram_wr_ena, 0);
      step();
      check("lat_edge2_ena", vram_wr_ena, 1);
      check("lat_edge2_addr", vram_wr_addr, 11859);
      check("lat_edge2_data", vram_wr_data, 16'hF81F);
      repeat (12) step();
      paint_once(0, 100, 50, 16'hF81F);
      check("p100_50_count", wr_addr.size(), 9);
      for (int i = 0; i < 9 && i < wr_addr.size(); i++) begin
         check($sformatf("p100_50_addr%0d", i), wr_addr[i], exp2[i]);
         check($sformatf("p100_50_data%0d", i), wr_data[i], 16'hF81F);
      end

      // Corners: clipping costs cycles but no writes.
      exp3a = '{0, 1, 240, 241};
      paint_once(0, 0, 0, 16'h1234);
      check("p0_0_count", wr_addr.size(), 4);
      check("p0_0_busy", busy_cnt, 9);
      for (int i = 0; i < 4 && i < wr_addr.size(); i++)
         check($sformatf("p0_0_addr%0d", i), wr_addr[i], exp3a[i]);
      exp3b = '{76558, 76559, 76798, 76799};
      paint_once(0, 239, 319, 16'h4321);
      check("p239_319_count", wr_addr.size(), 4);
      for (int i = 0; i < 4 && i < wr_addr.size(); i++)
         check($sformatf("p239_319_addr%0d", i), wr_addr[i], exp3b[i]);

      // Held touch over three service turns.
      set_point(0, 5, 5, 16'h0F0F);
`ifdef PAINTER_DEDUP_EN
      exp_n = 9;
`else
      exp_n = 27;
`endif
      hold_capture(2'b01, 25, 20);
      check("held_5_5_count", wr_addr.size(), exp_n);

      // Out-of-range x on ch1: no writes; leaves rr_ptr at 0.
      set_point(1, 240, 10, 16'hFFFF);
      hold_capture(2'b10, 10, 10);
      check("x240_count", wr_addr.size(), 0);
      check("x240_busy", busy_cnt, 0);

      // Two held channels alternate.
      set_point(0, 10, 10, 16'hAAAA);
      set_point(1, 200, 300, 16'h5555);
      hold_capture(2'b11, 25, 20);
`ifdef PAINTER_DEDUP_EN
      check("rr_count", wr_addr.size(), 18);
`else
      check("rr_count", wr_addr.size(), 27);
`endif
      for (int i = 0; i < 18 && i < wr_data.size(); i++)
         check($sformatf("rr_data%0d", i), wr_data[i], (i < 9) ? 16'hAAAA : 16'h5555);
`ifndef PAINTER_DEDUP_EN
      for (int i = 18; i < 27 && i < wr_data.size(); i++)
         check($sformatf("rr_data%0d", i), wr_data[i], 16'hAAAA);
`endif
      if (wr_addr.size() >= 10) begin
         check("rr_ch0_first", wr_addr[0], 2169);
         check("rr_ch0_last", wr_addr[8], 2651);
         check("rr_ch1_first", wr_addr[9], 71959);
      end else begin
         check("rr_burst_len", wr_addr.size(), 18);
      end

      // Abort a burst with clear_req sampled on the edge of its 4th write.
      bg_color = 16'h07E0;
      set_point(0, 20, 20, 16'hC0DE);
      touch_valid[0] = 1'b1;
      step();
      touch_valid = '0;
      cnt = 0;
      for (int i = 0; i < 20 && cnt < 3; i++) begin
         step();
         if (vram_wr_ena) cnt++;
      end
      check("abort_pre_writes", cnt, 3);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      check("abort_inflight_ena", vram_wr_ena, 1);
      check("abort_inflight_addr", vram_wr_addr, 4819);
      check("abort_inflight_data", vram_wr_data, 16'hC0DE);
      step();
      check("abort_clear_addr", vram_wr_addr, 76799);
      check("abort_clear_data", vram_wr_data, 16'h07E0);
      check("abort_clearing", clearing, 1);
      step();
      check("abort_clear_next", vram_wr_addr, 76798);

      // Asynchronous reset mid-clear, then restart.
      #2;
      rst = 1'b0;
      #1;
      check("midrst_ena", vram_wr_ena, 0);
      check("midrst_addr", vram_wr_addr, 0);
      check("midrst_data", vram_wr_data, 0);
      check("midrst_clearing", clearing, 1);
      check("midrst_busy", busy, 1);
      repeat (2) step();
      rst = 1'b1;
      step();
      check("restart_ena", vram_wr_ena, 1);
      check("restart_addr", vram_wr_addr, 76799);
      check("restart_data", vram_wr_data, 16'h07E0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
